// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register: one outstanding IMem request, 1-entry hold buffer, EX redirect flush.
// Optional IF_MISALIGN_CHK_EN: misaligned redirect targets raise sticky IF_Misalign and keep the old PC.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_Stall,
    input  logic        EX_PCSel,
    input  logic [31:0] EX_Target,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Valid,
    input  logic [31:0] IMem_Rdata,
    output logic [31:0] ID_Inst,
    output logic [31:0] ID_PC,
    output logic        ID_Valid
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        IF_Misalign
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        tgt_bad;
    logic [31:0] pc_inc;

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    assign tgt_bad     = (EX_Target[1:0] != 2'b00);
    assign IF_Misalign = misalign_q;
`else
    assign tgt_bad = 1'b0;
`endif

    assign pc_inc    = pc_q + 32'd4;
    assign IMem_Req  = rst & (state_q == S_REQ) & ~EX_PCSel;
    assign IMem_Addr = pc_q;
    assign ID_Inst   = id_inst_q;
    assign ID_PC     = id_pc_q;
    assign ID_Valid  = id_valid_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
`ifdef IF_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif
        if (EX_PCSel) begin
            // Redirect beats stall and response; an in-flight fetch must still be drained.
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
            if (!tgt_bad) begin
                pc_d = EX_Target;
            end
`ifdef IF_MISALIGN_CHK_EN
            else begin
                misalign_d = 1'b1;
            end
`endif
            case (state_q)
                S_WAIT, S_DROP: state_d = IMem_Valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            if (!ID_Stall) begin
                // Decode takes the current word this cycle; bubble unless refilled below.
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
            case (state_q)
                S_REQ: state_d = S_WAIT;
                S_WAIT: begin
                    if (IMem_Valid) begin
                        if (ID_Stall) begin
                            hold_d  = IMem_Rdata;
                            state_d = S_HOLD;
                        end else begin
                            id_inst_d  = IMem_Rdata;
                            id_pc_d    = pc_q;
                            id_valid_d = 1'b1;
                            pc_d       = pc_inc;
                            state_d    = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!ID_Stall) begin
                        id_inst_d  = hold_q;
                        id_pc_d    = pc_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (IMem_Valid) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            hold_q     <= 32'd0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= 32'd0;
            id_valid_q <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
`ifdef IF_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: variable-latency memory model, expected-word queue checked at decode, directed redirect/stall cases.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ID_Stall = 1'b0;
    logic        EX_PCSel = 1'b0;
    logic [31:0] EX_Target = 32'd0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Valid = 1'b0;
    logic [31:0] IMem_Rdata = 32'd0;
    logic [31:0] ID_Inst;
    logic [31:0] ID_PC;
    logic        ID_Valid;
`ifdef IF_MISALIGN_CHK_EN
    logic        IF_Misalign;
`endif

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ID_Stall   (ID_Stall),
        .EX_PCSel   (EX_PCSel),
        .EX_Target  (EX_Target),
        .IMem_Req   (IMem_Req),
        .IMem_Addr  (IMem_Addr),
        .IMem_Valid (IMem_Valid),
        .IMem_Rdata (IMem_Rdata),
        .ID_Inst    (ID_Inst),
        .ID_PC      (ID_PC),
        .ID_Valid   (ID_Valid)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .IF_Misalign(IF_Misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_cons = 0;
    int          lat = 1;
    logic        arm = 1'b0;
    logic        out_pend = 1'b0;
    logic        out_orphan = 1'b0;
    int          out_cnt = 0;
    logic [31:0] out_addr = 32'd0;
    logic [31:0] valid_addr = 32'd0;
    logic        valid_orphan = 1'b0;
    logic [31:0] exp_fetch = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'h5A3C_0000) + 32'h0000_1000;
    endfunction

    // Memory responds lat cycles after the request it saw.
    always @(posedge clk) begin
        #1;
        IMem_Valid = 1'b0;
        if (out_pend) begin
            if (out_cnt <= 1) begin
                IMem_Valid   = 1'b1;
                IMem_Rdata   = arm ? 32'h0050_0093 : memf(out_addr);
                arm          = 1'b0;
                valid_addr   = out_addr;
                valid_orphan = out_orphan;
                out_pend     = 1'b0;
                out_orphan   = 1'b0;
            end else begin
                out_cnt--;
            end
        end
    end

    // Scoreboard: consume at decode, flush on redirect, push accepted responses, track requests.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ID_Valid && !ID_Stall && !EX_PCSel) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("id_pc", ID_PC, e.pc);
                    chk("id_inst", ID_Inst, e.inst);
                    n_cons++;
                end
            end
            if (IMem_Valid && !valid_orphan && !EX_PCSel) begin
                sb.push_back({valid_addr, IMem_Rdata});
                exp_fetch = valid_addr + 32'd4;
            end
            if (EX_PCSel) begin
                sb.delete();
                if (out_pend) out_orphan = 1'b1;
`ifdef IF_MISALIGN_CHK_EN
                if (EX_Target[1:0] == 2'b00) exp_fetch = EX_Target;
`else
                exp_fetch = EX_Target;
`endif
            end
            if (IMem_Req) begin
                chk("one_outstanding", {31'd0, out_pend}, 32'd0);
                chk("fetch_addr", IMem_Addr, exp_fetch);
                out_pend   = 1'b1;
                out_addr   = IMem_Addr;
                out_cnt    = lat;
                out_orphan = 1'b0;
            end
        end
    end

    task automatic wait_req(input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (IMem_Req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_timeout", 32'd0, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [31:0] a;

        repeat (3) step();
        @(negedge clk);
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("rst_valid", {31'd0, ID_Valid}, 32'd0);
        chk("rst_inst", ID_Inst, NOP);
        chk("rst_pc", ID_PC, 32'd0);
`ifdef IF_MISALIGN_CHK_EN
        chk("rst_misalign", {31'd0, IF_Misalign}, 32'd0);
`endif
        step();
        rst = 1'b1;

        // Latency-1 cadence: requests in odd cycles, decode words in cycles 3,5,7.
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t1_req", {31'd0, IMem_Req}, {31'd0, (k % 2) == 1});
            if (k % 2 == 1) chk("t1_addr", IMem_Addr, 32'(4 * ((k - 1) / 2)));
            chk("t1_valid", {31'd0, ID_Valid}, {31'd0, (k == 3 || k == 5 || k == 7)});
            if (k >= 3 && k % 2 == 1) chk("t1_idpc", ID_PC, 32'(4 * ((k - 3) / 2)));
            step();
        end

        // Latency 3.
        lat = 3;
        c0 = n_cons;
        repeat (30) step();
        chk("t2_throughput", {31'd0, (n_cons - c0) >= 5}, 32'd1);

        // Stall while 0x00500093 arrives.
        lat = 1;
        wait_req(20);
        wait_req(20);
        a = IMem_Addr;
        arm = 1'b1;
        step();
        ID_Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_frz_valid", {31'd0, ID_Valid}, 32'd0);
            chk("t3_frz_inst", ID_Inst, NOP);
            chk("t3_frz_req", {31'd0, IMem_Req}, 32'd0);
            chk("t3_frz_addr", IMem_Addr, a);
            step();
        end
        ID_Stall = 1'b0;
        @(negedge clk);
        chk("t3_rel_addr", IMem_Addr, a);
        step();
        @(negedge clk);
        chk("t3_out_valid", {31'd0, ID_Valid}, 32'd1);
        chk("t3_out_inst", ID_Inst, 32'h0050_0093);
        chk("t3_out_pc", ID_PC, a);
        chk("t3_next_addr", IMem_Addr, a + 32'd4);

        // Redirect while waiting on a slow response.
        lat = 3;
        wait_req(20);
        step();
        EX_PCSel = 1'b1;
        EX_Target = 32'h0000_0100;
        step();
        EX_PCSel = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'd0, ID_Valid}, 32'd0);
        chk("t4_inst", ID_Inst, NOP);
        wait_req(20);
        chk("t4_addr", IMem_Addr, 32'h0000_0100);

        // Redirect coincident with response and stall.
        lat = 1;
        wait_req(20);
        wait_req(20);
        step();
        EX_PCSel = 1'b1;
        EX_Target = 32'h0000_0100;
        ID_Stall = 1'b1;
        step();
        EX_PCSel = 1'b0;
        ID_Stall = 1'b0;
        @(negedge clk);
        chk("t5_valid", {31'd0, ID_Valid}, 32'd0);
        chk("t5_req", {31'd0, IMem_Req}, 32'd1);
        chk("t5_addr", IMem_Addr, 32'h0000_0100);

        // Back-to-back redirects: last target wins.
        lat = 3;
        wait_req(20);
        step();
        EX_PCSel = 1'b1;
        EX_Target = 32'h0000_0200;
        step();
        EX_Target = 32'h0000_0300;
        step();
        EX_PCSel = 1'b0;
        wait_req(20);
        chk("b2b_addr", IMem_Addr, 32'h0000_0300);

        // PC wrap.
        lat = 1;
        wait_req(20);
        step();
        EX_PCSel = 1'b1;
        EX_Target = 32'hFFFF_FFF8;
        step();
        EX_PCSel = 1'b0;
        wait_req(20);
        chk("wrap_a0", IMem_Addr, 32'hFFFF_FFF8);
        wait_req(20);
        chk("wrap_a1", IMem_Addr, 32'hFFFF_FFFC);
        wait_req(20);
        chk("wrap_a2", IMem_Addr, 32'h0000_0000);

`ifdef IF_MISALIGN_CHK_EN
        lat = 3;
        wait_req(20);
        a = IMem_Addr;
        step();
        EX_PCSel = 1'b1;
        EX_Target = 32'h0000_0102;
        step();
        EX_PCSel = 1'b0;
        @(negedge clk);
        chk("mis_flag", {31'd0, IF_Misalign}, 32'd1);
        chk("mis_valid", {31'd0, ID_Valid}, 32'd0);
        wait_req(20);
        chk("mis_addr", IMem_Addr, a);
        repeat (10) step();
        chk("mis_sticky", {31'd0, IF_Misalign}, 32'd1);
`endif

        repeat (20) step();
        chk("consumed", {31'd0, n_cons > 10}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
